// File: rtl/path_tracer.sv
// Back-traces a shortest path from a destination node to its source by
// following per-node predecessor directions, emitting one step per node.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// FETCH  | node read strobe issued for cur
// EVAL   | read data returned; decide unreachable or build step
// EMIT   | step presented, waiting for the handshake
// FINISH | one-cycle done pulse, err/step_count final
module path_tracer #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int CW        = 8,
  parameter int MAX_STEPS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] dst_x,
  input  logic [CW-1:0] dst_y,
  output logic          rd_en,
  output logic [CW-1:0] rd_x,
  output logic [CW-1:0] rd_y,
  input  logic [15:0]   rd_cost,
  input  logic [2:0]    rd_dir,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [CW-1:0] step_x,
  output logic [CW-1:0] step_y,
  output logic [2:0]    step_dir,
  output logic          step_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [CW:0]   step_count
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, FINISH} state_t;

  localparam logic [CW:0] W_LIM = (CW+1)'(GRID_W);
  localparam logic [CW:0] H_LIM = (CW+1)'(GRID_H);
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_STEPS);
  localparam logic [CW:0] P_ONE = (CW+1)'(1);
  localparam logic [CW:0] M_ONE = '1;

  state_t        state;
  logic [CW-1:0] cur_x, cur_y;
  logic [CW:0]   dx, dy, nx, ny, cnt_inc;
  logic          off_grid, dst_bad;

  assign rd_x = cur_x;
  assign rd_y = cur_y;

  // One extra bit keeps a step below zero distinct from the grid interior:
  // -1 wraps to all-ones, which is always >= the limit.
  always_comb begin
    dx = '0;
    dy = '0;
    case (step_dir)
      3'd0: dy = M_ONE;
      3'd1: begin dx = P_ONE; dy = M_ONE; end
      3'd2: dx = P_ONE;
      3'd3: begin dx = P_ONE; dy = P_ONE; end
      3'd4: dy = P_ONE;
      3'd5: begin dx = M_ONE; dy = P_ONE; end
      3'd6: dx = M_ONE;
      default: begin dx = M_ONE; dy = M_ONE; end
    endcase
    nx       = {1'b0, cur_x} + dx;
    ny       = {1'b0, cur_y} + dy;
    off_grid = (nx >= W_LIM) || (ny >= H_LIM);
    cnt_inc  = step_count + 1'b1;
    dst_bad  = ({1'b0, dst_x} >= W_LIM) || ({1'b0, dst_y} >= H_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      rd_en      <= 1'b0;
      step_valid <= 1'b0;
      step_x     <= '0;
      step_y     <= '0;
      step_dir   <= '0;
      step_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= '0;
      step_count <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            err        <= 2'd0;
            step_count <= '0;
            cur_x      <= dst_x;
            cur_y      <= dst_y;
            if (dst_bad) begin
              err   <= 2'd2;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              rd_en <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FETCH: state <= EVAL;
        EVAL: begin
          if (rd_cost == 16'hFFFF) begin
            err   <= 2'd1;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            step_x     <= cur_x;
            step_y     <= cur_y;
            step_dir   <= rd_dir;
            step_last  <= (rd_cost == 16'd0);
            step_valid <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (step_ready) begin
            step_valid <= 1'b0;
            step_count <= cnt_inc;
            if (step_last) begin
              err   <= 2'd0;
              done  <= 1'b1;
              state <= FINISH;
            end else if (cnt_inc == MAX_C) begin
              err   <= 2'd3;
              done  <= 1'b1;
              state <= FINISH;
            end else if (off_grid) begin
              err   <= 2'd2;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              cur_x <= nx[CW-1:0];
              cur_y <= ny[CW-1:0];
              rd_en <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/path_tracer.md
PATH_TRACER -- requirements
Module: path_tracer

Interface
REQ-001 SHALL have parameter GRID_W, default 16, grid width in nodes (x range 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 16, grid height in nodes (y range 0..GRID_H-1).
REQ-003 SHALL have parameter CW, default 8, coordinate width in bits; GRID_W, GRID_H <= 2^CW.
REQ-004 SHALL have parameter MAX_STEPS, default 256, maximum emitted steps per trace.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: start  in  1  begin trace; dst_x, dst_y  in  CW each  trace start node.
REQ-007 SHALL have ports: rd_en  out  1  node read strobe; rd_x, rd_y  out  CW each  node address.
REQ-008 SHALL have ports: rd_cost  in  16  node path cost; rd_dir  in  3  node predecessor direction; both valid exactly 1 cycle after rd_en.
REQ-009 SHALL have ports: step_valid  out  1; step_ready  in  1; step_x, step_y  out  CW each; step_dir  out  3; step_last  out  1.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; err  out  2  result code; step_count  out  CW+1  steps accepted.

Function
REQ-011 SHALL walk from (dst_x,dst_y) back to the source node (cost 0) by following rd_dir at each node, emitting one step per node visited.
REQ-012 SHALL map direction to predecessor offset: 0=N(y-1), 1=NE(x+1,y-1), 2=E(x+1), 3=SE(x+1,y+1), 4=S(y+1), 5=SW(x-1,y+1), 6=W(x-1), 7=NW(x-1,y-1).
REQ-013 SHALL implement states IDLE, FETCH, EVAL, EMIT, FINISH.
REQ-014 IDLE: busy=0; start=1 latches dst into cur, clears step_count and err, enters FETCH; start while busy=1 SHALL be ignored.
REQ-015 IDLE: start with dst_x>=GRID_W or dst_y>=GRID_H SHALL go to FINISH with err=2 and no read issued.
REQ-016 FETCH: rd_en=1, rd_x/rd_y=cur for exactly one cycle; next EVAL. rd_en SHALL be 0 in all other states.
REQ-017 EVAL: rd_cost=16'hFFFF SHALL go to FINISH with err=1 (unreachable); otherwise register step_x/y=cur, step_dir=rd_dir, step_last=(rd_cost==0), enter EMIT.
REQ-018 EMIT: step_valid=1; step_x/y/dir/last SHALL hold stable until step_valid&&step_ready; step_count increments on each handshake.
REQ-019 EMIT handshake with step_last=1: FINISH, err=0.
REQ-020 EMIT handshake with step_last=0: compute next=cur+offset(step_dir); next outside grid (x or y below 0 or at/above limit) SHALL give FINISH err=2.
REQ-021 EMIT handshake when the accepted step makes step_count==MAX_STEPS and step_last=0: FINISH err=3 (loop/limit), taking priority over err=2.
REQ-022 Otherwise cur<=next, enter FETCH; minimum 3 cycles per step with step_ready held high.
REQ-023 FINISH: done=1 for one cycle, busy=1, then IDLE; err and step_count SHALL hold until next accepted start.
REQ-024 busy SHALL be 1 in FETCH, EVAL, EMIT, FINISH.
REQ-025 Coordinate arithmetic SHALL be CW+1 bits signed-safe so x=0 with W-direction is detected as off-grid, not wrapped.
REQ-026 step_ready when step_valid=0 SHALL have no effect.

Reset
REQ-027 rst SHALL force IDLE, busy=0, done=0, rd_en=0, step_valid=0, step_last=0, step_x/y=0, step_dir=0, err=0, step_count=0, regardless of state.
REQ-028 rst mid-trace SHALL abandon the trace with no done pulse; start in the same cycle as rst SHALL be ignored.

Verification
REQ-029 Direct path: source (2,2) cost 0, node (4,2) dir 6 cost 4, node (3,2) dir 6 cost 2, start dst=(4,2), step_ready=1 -> steps (4,2,6,0),(3,2,6,0),(2,2,x,1); done, err=0, step_count=3.
REQ-030 Back-pressure: same grid, step_ready low 5 cycles during first EMIT -> step_valid held, step_x=4 stable, no extra rd_en, final result identical.
REQ-031 Unreachable: dst (7,7) with rd_cost=16'hFFFF -> no step emitted, done with err=1, step_count=0.
REQ-032 Off-grid: dst (0,5) dir 6 cost 3 -> one step (0,5) emitted, then done err=2, step_count=1; dst=(16,0) -> done err=2 with rd_en never asserted.
REQ-033 Loop: MAX_STEPS=4, nodes (1,1) dir 2 and (2,1) dir 6 both cost 5 -> exactly 4 steps alternating, done err=3, step_count=4.
REQ-034 Reset mid-trace: assert rst during EMIT of step 2 -> next cycle busy=0, step_valid=0, no done; new start then traces normally.
